// File: rtl/cby_ft_pkg.sv
// Shared definitions for the retiming feedthrough connection block:
// per-track mode encodings and the legal pipeline depth range.
package cby_ft_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_REG1 = 2'b01,
        MODE_REGD = 2'b10,
        MODE_OFF  = 2'b11
    } ft_mode_e;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;

endpackage

// File: rtl/cby_ft_track.sv
// One routing track: a free-running DEPTH-stage shift register and a 4:1 mux
// choosing pass-through, 1-cycle tap, DEPTH-cycle tap, or a constant 0.
module cby_ft_track
    import cby_ft_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic [1:0] mode,
    output logic       dout
);

    logic [DEPTH-1:0] pipe;

    // The pipeline never stalls, so a mode switch only re-points the mux and
    // the selected tap already holds valid history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[DEPTH-2:0], din};
        end
    end

    always_comb begin
        dout = 1'b0;
        case (mode)
            MODE_PASS: dout = din;
            MODE_REG1: dout = pipe[0];
            MODE_REGD: dout = pipe[DEPTH-1];
            default:   dout = 1'b0;
        endcase
    end

endmodule

// File: rtl/cby_retime_feedthrough.sv
// Vertical connection-block feedthrough with per-track retiming, configured by
// a 4*WIDTH-bit serial chain (two mode bits per track, northbound first).
module cby_retime_feedthrough
    import cby_ft_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             config_enable,
    input  logic             ccff_head,
    output logic             ccff_tail,
    input  logic             Test_en,
    input  logic [WIDTH-1:0] chany_bottom_in,
    input  logic [WIDTH-1:0] chany_top_in,
    output logic [WIDTH-1:0] chany_top_out,
    output logic [WIDTH-1:0] chany_bottom_out
);

    localparam int CFG_BITS = 4 * WIDTH;

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("cby_retime_feedthrough: DEPTH=%0d outside legal range %0d..%0d",
               DEPTH, DEPTH_MIN, DEPTH_MAX);
    end

    logic [CFG_BITS-1:0] cfg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg <= '0;
        end else if (config_enable) begin
            cfg <= {cfg[CFG_BITS-2:0], ccff_head};
        end
    end

    assign ccff_tail = cfg[CFG_BITS-1];

    // Loading the chain blanks every track; test mode bypasses all retiming.
    function automatic logic [1:0] effective_mode(input logic [1:0] cfg_mode,
                                                  input logic       cfg_en,
                                                  input logic       test_en);
        logic [1:0] m;
        m = cfg_mode;
        if (cfg_en) begin
            m = MODE_OFF;
        end else if (test_en) begin
            m = MODE_PASS;
        end
        return m;
    endfunction

    for (genvar t = 0; t < WIDTH; t++) begin : g_track
        logic [1:0] north_mode;
        logic [1:0] south_mode;

        assign north_mode = effective_mode(cfg[2*t +: 2], config_enable, Test_en);
        assign south_mode = effective_mode(cfg[2*WIDTH + 2*t +: 2], config_enable, Test_en);

        cby_ft_track #(
            .DEPTH (DEPTH)
        ) u_north (
            .clk   (clk),
            .reset (reset),
            .din   (chany_bottom_in[t]),
            .mode  (north_mode),
            .dout  (chany_top_out[t])
        );

        cby_ft_track #(
            .DEPTH (DEPTH)
        ) u_south (
            .clk   (clk),
            .reset (reset),
            .din   (chany_top_in[t]),
            .mode  (south_mode),
            .dout  (chany_bottom_out[t])
        );
    end

endmodule

// File: doc/cby_retime_feedthrough.md
CBY_RETIME_FEEDTHROUGH -- requirements
Module: cby_retime_feedthrough

Interface
REQ-001 Parameter WIDTH, default 20: routing tracks per direction.
REQ-002 Parameter DEPTH, default 2, legal range 2..8: pipeline stages in deep-retime mode.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port config_enable, input, 1: high = config chain shifts and channel outputs are forced low.
REQ-006 Port ccff_head, input, 1: config chain serial input.
REQ-007 Port ccff_tail, output, 1: config chain serial output.
REQ-008 Port Test_en, input, 1: high = every track forced to combinational pass-through.
REQ-009 Port chany_bottom_in, input, WIDTH: tracks travelling north.
REQ-010 Port chany_top_in, input, WIDTH: tracks travelling south.
REQ-011 Port chany_top_out, output, WIDTH: northbound tracks after retiming.
REQ-012 Port chany_bottom_out, output, WIDTH: southbound tracks after retiming.

Function
REQ-013 Config register cfg shall be 4*WIDTH bits; when config_enable=1, each edge does cfg[0]<=ccff_head and cfg[i]<=cfg[i-1].
REQ-014 When config_enable=0, cfg shall hold.
REQ-015 ccff_tail shall equal cfg[4*WIDTH-1] (registered, no combinational path from ccff_head).
REQ-016 Northbound track t mode = {cfg[2t+1],cfg[2t]}; southbound track t mode = {cfg[2*WIDTH+2t+1],cfg[2*WIDTH+2t]}.
REQ-017 Mode 00: out[t] = in[t] combinationally (latency 0).
REQ-018 Mode 01: out[t] = in[t] delayed by exactly 1 clk.
REQ-019 Mode 10: out[t] = in[t] delayed by exactly DEPTH clks.
REQ-020 Mode 11: out[t] = 0 (track disabled).
REQ-021 Each track shall have a DEPTH-stage shift register that shifts every edge regardless of mode, config_enable, or Test_en; mode 01 taps stage 1, mode 10 taps stage DEPTH.
REQ-022 Mode change shall take effect on the output mux in the same cycle cfg changes, with no pipeline flush; in-flight data remains valid.
REQ-023 Output priority: config_enable=1 forces all outputs 0. Otherwise Test_en=1 forces mode 00. Otherwise the configured mode applies.
REQ-024 The two directions are fully independent; no data path crosses between them.

Reset
REQ-025 reset=1 shall asynchronously clear cfg (all tracks mode 00), all pipeline stages, and ccff_tail to 0.
REQ-026 During and after reset with config_enable=0, outputs shall equal inputs combinationally.
REQ-027 Reset asserted mid-shift shall abort loading; after release, cfg=0 and shifting resumes from empty.
REQ-028 On the first edge after reset release, pipeline stage 1 shall capture the input; a mode-10 output is 0 for DEPTH cycles, then delayed data.

Structure
REQ-029 Shared package cby_ft_pkg shall hold the mode encodings (MODE_PASS=00, MODE_REG1=01, MODE_REGD=10, MODE_OFF=11) and the DEPTH legal range bounds.
REQ-030 Sub-module cby_ft_track (one track: DEPTH-stage shift register plus 4:1 mode mux) shall be instantiated 2*WIDTH times.
REQ-031 The top level shall contain only the config chain, Test_en/config_enable override, and track instances.
REQ-032 DEPTH outside 2..8 shall produce an elaboration error.

Verification
REQ-033 After reset, config_enable=0, drive chany_bottom_in=20'hA5A5A -> chany_top_out=20'hA5A5A in the same cycle.
REQ-034 Shift 80 bits placing northbound track 0 in mode 01 and track 1 in mode 10 (DEPTH=2); pulse bottom_in[0] and bottom_in[1] high for 1 cycle -> top_out[0] high exactly 1 cycle later, top_out[1] high exactly 2 cycles later.
REQ-035 Shift an 80-bit pattern, then shift 80 more bits of zeros -> ccff_tail reproduces the first pattern bit-exact starting 80 cycles after its first bit entered; all outputs 0 while config_enable=1.
REQ-036 All tracks in mode 11, Test_en=1, top_in=20'hFFFFF -> bottom_out=20'hFFFFF combinationally; Test_en=0 -> 0.
REQ-037 Track in mode 10 streaming an incrementing pattern; switch it to mode 01 mid-stream -> output jumps to the 1-cycle-delayed value with no X or stale zero; drive reset mid-stream -> outputs revert to pass-through immediately.
